// File: rtl/xilinx_primitive_pkg.sv
// rtl/xilinx_primitive_pkg.sv - shared constants and helpers for FIFO primitive wrappers
package xilinx_primitive_pkg;

    // Extra output-buffer entries beyond the read latency: one to cover the
    // registered head and one so issue can continue while a pop is pending.
    localparam int FIFO_RD_OBUF_EXTRA = 2;

    // Cycles from RDEN to valid DO on a non-FWFT FIFO.
    function automatic int fifo_read_latency(input int do_reg);
        return 1 + do_reg;
    endfunction

endpackage

// File: rtl/xilinx_fifo_rd_obuf.sv
// rtl/xilinx_fifo_rd_obuf.sv - small circular output buffer with non-power-of-two depth
module xilinx_fifo_rd_obuf #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [2:0]            level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (level != 3'd0);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy; simultaneous push and pop keep level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
        end
    end

    // The issue credit keeps pushes away from a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> ((level < 3'(DEPTH)) || do_pop));

endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// rtl/xilinx_fifo_rd_stream.sv - non-FWFT FIFO read port to valid/ready stream adapter
module xilinx_fifo_rd_stream
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DO_REG     = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_DO,
    input  logic                  FIFO_RDERR,
    output logic                  FIFO_RDEN,
    output logic                  M_VALID,
    output logic [DATA_WIDTH-1:0] M_DATA,
    input  logic                  M_READY,
    output logic [2:0]            BUF_LEVEL,
    output logic                  RDERR_STICKY
);

    localparam int LAT        = fifo_read_latency(DO_REG);
    localparam int OBUF_DEPTH = LAT + FIFO_RD_OBUF_EXTRA;

    logic [LAT-1:0] inflight_vld;
    logic [2:0]     inflight;
    logic [3:0]     credit_used;
    logic           push;
    logic           pop;

    // Count reads issued but not yet landed in the buffer.
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 3'(inflight_vld[i]);
        end
    end

    // Issue only when every outstanding read is guaranteed a buffer slot.
    assign credit_used = 4'(inflight) + 4'(BUF_LEVEL);
    assign FIFO_RDEN   = !FIFO_EMPTY && (credit_used < 4'(OBUF_DEPTH));

    assign push    = inflight_vld[LAT-1];
    assign M_VALID = (BUF_LEVEL != 3'd0);
    assign pop     = M_VALID && M_READY;

    // Shift each issued read toward the cycle its data appears on FIFO_DO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight_vld <= '0;
        end else begin
            inflight_vld <= LAT'({inflight_vld, FIFO_RDEN});
        end
    end

    // Latch any read error until reset; it should never fire.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDERR_STICKY <= 1'b0;
        end else if (FIFO_RDERR) begin
            RDERR_STICKY <= 1'b1;
        end
    end

    xilinx_fifo_rd_obuf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (OBUF_DEPTH)
    ) u_obuf (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_data(FIFO_DO),
        .pop      (pop),
        .head     (M_DATA),
        .level    (BUF_LEVEL)
    );

endmodule
